// File: rtl/oparb_pkg.sv
// Shared constants and helpers for the output-port round-robin arbiter.
// NREQ must stay within 2..8 and 2**PTR_W must cover NREQ.
package oparb_pkg;

    localparam int unsigned NREQ  = 5;
    localparam int unsigned PTR_W = 3;

    localparam int unsigned IDX_PE = 0;
    localparam int unsigned IDX_S  = 1;
    localparam int unsigned IDX_N  = 2;
    localparam int unsigned IDX_E  = 3;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic {
        VcEven = 1'b0,
        VcOdd  = 1'b1
    } vc_e;

    // Wrap by explicit compare so a non-power-of-two NREQ rotates correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module rr_pick
    import oparb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    // Doubled vector turns the wrapped scan into a plain upward search.
    logic [2*NREQ-1:0] req2;
    logic [PTR_W-1:0]  base;

    assign req2 = {req, req};
    assign base = (ptr < PTR_W'(NREQ)) ? ptr : '0;

    always_comb begin
        int pos;
        int wrapped;
        any     = 1'b0;
        idx     = '0;
        onehot  = '0;
        pos     = 0;
        wrapped = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            pos     = int'(base) + k;
            wrapped = (pos >= int'(NREQ)) ? pos - int'(NREQ) : pos;
            if (!any && req2[pos]) begin
                any             = 1'b1;
                idx             = PTR_W'(wrapped);
                onehot[wrapped] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oparb.sv
// Per-output-port round-robin arbiter with independent fairness pointers for
// the even and odd virtual channels; grants only into an empty VC buffer.
module oparb
    import oparb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            polarity,
    input  logic [NREQ-1:0] req_even,
    input  logic [NREQ-1:0] req_odd,
    input  logic            empty_even,
    input  logic            empty_odd,
    output logic [NREQ-1:0] grant,
    output logic            grant_vc,
    output logic            grant_valid
);

    logic [NREQ-1:0]  grant_q, grant_d;
    logic             grant_vc_q, grant_vc_d;
    logic             grant_valid_q, grant_valid_d;
    logic [PTR_W-1:0] ptr_even_q, ptr_even_d;
    logic [PTR_W-1:0] ptr_odd_q, ptr_odd_d;
    logic [NREQ-1:0]  last_grant_q, last_grant_d;
    vc_e              last_vc_q, last_vc_d;

    logic [NREQ-1:0]  eff_even, eff_odd;
    logic             any_even, any_odd;
    logic [PTR_W-1:0] idx_even, idx_odd;
    logic [NREQ-1:0]  oh_even, oh_odd;

    // Mask the requester granted last cycle on this VC: its buffer-empty flag
    // has not yet dropped, so it would otherwise win twice.
    always_comb begin
        eff_even = req_even;
        eff_odd  = req_odd;
        if (last_vc_q == VcEven) begin
            eff_even = req_even & ~last_grant_q;
        end else begin
            eff_odd  = req_odd & ~last_grant_q;
        end
    end

    rr_pick u_pick_even (
        .req    (eff_even),
        .ptr    (ptr_even_q),
        .any    (any_even),
        .idx    (idx_even),
        .onehot (oh_even)
    );

    rr_pick u_pick_odd (
        .req    (eff_odd),
        .ptr    (ptr_odd_q),
        .any    (any_odd),
        .idx    (idx_odd),
        .onehot (oh_odd)
    );

    always_comb begin
        grant_d       = '0;
        grant_vc_d    = polarity;
        grant_valid_d = 1'b0;
        ptr_even_d    = ptr_even_q;
        ptr_odd_d     = ptr_odd_q;
        last_grant_d  = '0;
        last_vc_d     = VcEven;
        if (polarity == VcOdd) begin
            if (empty_odd && any_odd) begin
                grant_d       = oh_odd;
                grant_valid_d = 1'b1;
                ptr_odd_d     = ptr_inc(idx_odd);
                last_grant_d  = oh_odd;
                last_vc_d     = VcOdd;
            end
        end else begin
            if (empty_even && any_even) begin
                grant_d       = oh_even;
                grant_valid_d = 1'b1;
                ptr_even_d    = ptr_inc(idx_even);
                last_grant_d  = oh_even;
                last_vc_d     = VcEven;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= '0;
            grant_vc_q    <= 1'b0;
            grant_valid_q <= 1'b0;
            ptr_even_q    <= '0;
            ptr_odd_q     <= '0;
            last_grant_q  <= '0;
            last_vc_q     <= VcEven;
        end else begin
            grant_q       <= grant_d;
            grant_vc_q    <= grant_vc_d;
            grant_valid_q <= grant_valid_d;
            ptr_even_q    <= ptr_even_d;
            ptr_odd_q     <= ptr_odd_d;
            last_grant_q  <= last_grant_d;
            last_vc_q     <= last_vc_d;
        end
    end

    assign grant       = grant_q;
    assign grant_vc    = grant_vc_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_oparb.sv
// Randomised plus directed bench for oparb; a queue-based scoreboard checks
// every registered grant against a behavioural round-robin model.
module tb_oparb;
    import oparb_pkg::*;

    logic            clk;
    logic            reset;
    logic            polarity;
    logic [NREQ-1:0] req_even;
    logic [NREQ-1:0] req_odd;
    logic            empty_even;
    logic            empty_odd;
    logic [NREQ-1:0] grant;
    logic            grant_vc;
    logic            grant_valid;

    oparb dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .req_even    (req_even),
        .req_odd     (req_odd),
        .empty_even  (empty_even),
        .empty_odd   (empty_odd),
        .grant       (grant),
        .grant_vc    (grant_vc),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic            vc;
        logic            v;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    bit   done     = 1'b0;

    // Reference state: a pointer per VC and the requester granted last cycle.
    int m_ptr[2];
    int m_last;
    int m_last_vc;

    task automatic model(input bit rst, input bit pol, input logic [NREQ-1:0] re,
                         input logic [NREQ-1:0] ro, input bit ee, input bit eo);
        exp_t e;
        logic [NREQ-1:0] r;
        bit emp;
        int win;
        int i;
        if (rst) begin
            m_ptr[0]  = 0;
            m_ptr[1]  = 0;
            m_last    = -1;
            m_last_vc = 0;
            e = '{g: '0, vc: 1'b0, v: 1'b0};
        end else begin
            r   = pol ? ro : re;
            emp = pol ? eo : ee;
            if (m_last >= 0 && m_last_vc == int'(pol)) r[m_last] = 1'b0;
            win = -1;
            for (int off = 0; off < int'(NREQ); off++) begin
                i = (m_ptr[pol] + off) % int'(NREQ);
                if (win < 0 && r[i]) win = i;
            end
            if (emp && win >= 0) begin
                e.g          = '0;
                e.g[win]     = 1'b1;
                e.vc         = pol;
                e.v          = 1'b1;
                m_ptr[pol]   = (win + 1) % int'(NREQ);
                m_last       = win;
                m_last_vc    = int'(pol);
            end else begin
                e = '{g: '0, vc: pol, v: 1'b0};
                m_last = -1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus; its result appears after the next posedge.
    task automatic step(input bit rst, input bit pol, input logic [NREQ-1:0] re,
                        input logic [NREQ-1:0] ro, input bit ee, input bit eo);
        reset      = rst;
        polarity   = pol;
        req_even   = re;
        req_odd    = ro;
        empty_even = ee;
        empty_odd  = eo;
        model(rst, pol, re, ro, ee, eo);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a registered decision.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_cnt++;
                if (grant === e.g && grant_vc === e.vc && grant_valid === e.v) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL grant_cycle t=%0t: got grant=%b vc=%b valid=%b want grant=%b vc=%b valid=%b",
                             $time, grant, grant_vc, grant_valid, e.g, e.vc, e.v);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] ra, rb;
        // Reset held two cycles with full requests and an empty buffer.
        step(1, 0, 5'b11111, '0, 1, 1);
        step(1, 0, 5'b11111, '0, 1, 1);
        step(0, 0, 5'b11111, '0, 1, 1);
        step(0, 0, 5'b11111, '0, 1, 1);
        // Rotation over a sparse request set.
        step(1, 0, '0, '0, 1, 1);
        for (int k = 0; k < 8; k++) step(0, 0, 5'b10110, '0, 1, 1);
        // Backpressure, then release.
        for (int k = 0; k < 3; k++) step(0, 0, 5'b01000, '0, 0, 1);
        for (int k = 0; k < 2; k++) step(0, 0, 5'b01000, '0, 1, 1);
        // VC independence with alternating polarity.
        step(1, 0, '0, '0, 1, 1);
        for (int k = 0; k < 10; k++) step(0, k[0], 5'b00011, 5'b11000, 1, 1);
        // Odd request while polarity stays even must wait.
        for (int k = 0; k < 3; k++) step(0, 0, '0, 5'b00100, 1, 1);
        step(0, 1, '0, 5'b00100, 1, 1);
        // Single requester alternates with idle cycles.
        for (int k = 0; k < 6; k++) step(0, 0, 5'b00100, '0, 1, 1);
        // Reset right after a grant drops it and restarts priority at PE.
        step(1, 0, '0, '0, 1, 1);
        step(0, 0, 5'b00010, '0, 1, 1);
        step(1, 0, 5'b00010, '0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 5'b11111, '0, 1, 1);
        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            ra = NREQ'($urandom);
            rb = NREQ'($urandom);
            step(($urandom_range(0, 49) == 0), 1'($urandom),
                 ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        step(0, 0, '0, '0, 1, 1);
        repeat (3) @(posedge clk);
        done = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/oparb.md
Name: oparb

Overview:
- Round-robin arbiter for one router output port.
- Picks one of five input ports (PE, S, N, E, W) per cycle. Issues a registered one-hot grant to the output port controller (opctrl), which latches data into its even or odd virtual-channel (VC) buffer.
- Keeps independent fairness state per VC. Only grants when the target VC buffer is empty.
- One oparb instance per output port, alongside its opctrl.

Parameters:
- NREQ, 5, number of requesters; bit order 0=PE, 1=S, 2=N, 3=E, 4=W (legal range 2..8).
- PTR_W, 3, pointer width; must satisfy 2**PTR_W >= NREQ.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- polarity  in  1  current cycle VC select; 0 = even, 1 = odd
- req_even  in  NREQ  per-input request for the even VC of this output
- req_odd  in  NREQ  per-input request for the odd VC of this output
- empty_even  in  1  opctrl even-VC buffer empty
- empty_odd  in  1  opctrl odd-VC buffer empty
- grant  out  NREQ  registered one-hot grant; all-zero = no grant
- grant_vc  out  1  VC the current grant belongs to (polarity at decision)
- grant_valid  out  1  registered, equals OR of grant

Behaviour:
- Reset:
  - grant=0, grant_vc=0, grant_valid=0.
  - ptr_even=0, ptr_odd=0 (PE highest priority).
  - last_grant=0.
  - Reset wins over any same-cycle request. Reset mid-operation drops any grant in flight; grant is zero the cycle after reset is sampled.
- Decision, each non-reset posedge:
  - Select VC v = polarity.
  - Effective request = req_v AND NOT mask.
  - mask = last_grant if last_grant_vc == v, else 0. This blocks re-granting the same requester on the same VC in the immediately following cycle, before empty_v falls.
  - If empty_v = 1 and effective request != 0: the winner is the first set bit scanning from index ptr_v upward, wrapping modulo NREQ.
    - grant <= onehot(winner), grant_vc <= v, grant_valid <= 1.
    - ptr_v <= (winner+1) mod NREQ; the wrap uses explicit compare, not power-of-two overflow.
  - Otherwise: grant <= 0, grant_valid <= 0, grant_vc <= v; both pointers hold.
  - Only ptr_v can change; the other VC's pointer never moves that cycle.
- last_grant / last_grant_vc register the grant and VC just issued; they are cleared when no grant is issued.
- Latency: request and empty sampled at edge t; grant visible from edge t to edge t+1 (one cycle). opctrl samples it with data at edge t+1.
- A grant lasts exactly one cycle; there is no hold or lock. A requester must keep req asserted until its own clear from opctrl.
- Simultaneous events:
  - All five requesting: strict rotation 0,1,2,3,4,0,... per VC.
  - A request for VC v arriving while polarity != v waits; no grant and no pointer change for v.
- empty_v = 0: no grant for v regardless of requests (buffer full backpressure).
- No combinational path from any input to any output.

Decomposition:
- Package oparb_pkg: NREQ, PTR_W, index constants IDX_PE=0, IDX_S=1, IDX_N=2, IDX_E=3, IDX_W=4.
- Sub-module rr_pick: combinational; inputs req[NREQ], ptr[PTR_W]; outputs any, idx[PTR_W], onehot[NREQ].
  - Instantiated twice, one per VC. The VC mux selects its result; this keeps the pointer logic symmetric.

Test Plan:
- Reset:
  - Assert reset 2 cycles with req_even=5'b11111, empty_even=1 -> grant=0, grant_valid=0 throughout.
  - After release at polarity=0 -> first grant=5'b00001, grant_vc=0.
- Rotation:
  - Hold polarity=0, empty_even=1, req_even=5'b10110 -> grants sequence 00010, 00100, 10000, 00010, ...
  - No requester is granted twice consecutively.
- Backpressure:
  - req_even=5'b01000, empty_even=0 for 3 cycles -> grant=0 and ptr_even unchanged.
  - Raise empty_even -> grant=5'b01000 one cycle later.
- VC independence:
  - Toggle polarity each cycle, req_even=5'b00011, req_odd=5'b11000, both empties=1.
  - Even grants alternate 00001/00010 and odd grants alternate 01000/10000.
  - grant_vc matches the polarity of the decision cycle.
- Single-requester mask:
  - polarity=0 fixed, req_even=5'b00100, empty_even=1 -> grant 00100, 00000, 00100, 00000, ...
- Reset mid-operation:
  - Assert reset the cycle after grant=5'b00010 -> grant=0 next cycle, ptr_even=0.
  - With req_even=5'b11111 afterwards -> next grant=5'b00001.
